// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// result-source codes, FSM states and the forwarding-priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE        = 2'b00;
  localparam logic [1:0] FWD_WB          = 2'b01;
  localparam logic [1:0] FWD_MEM         = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MC_WAIT  = 2'b01,
    MC_DRAIN = 2'b10
  } hazState_t;

  // The M stage holds the younger write, so its match outranks W.
  function automatic logic [1:0] fwdSel(input logic [4:0] rs,
                                        input logic [4:0] rdM, input logic wrM,
                                        input logic [4:0] rdW, input logic wrW);
    if (wrM && (rdM != 5'd0) && (rdM == rs))      return FWD_MEM;
    else if (wrW && (rdW != 5'd0) && (rdW == rs)) return FWD_WB;
    else                                          return FWD_NONE;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding select for both Execute ALU inputs.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  assign ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// branch flushes, forwarding and iterative mul/div wait. Macro HAZ_PERF_CNT_EN adds perf counters.
//
// state    | meaning
// RUN      | normal flow; load-use and control hazards handled
// MC_WAIT  | multi-cycle op in E; F/D/E held, bubbles into M, timeout armed
// MC_DRAIN | result ready; E advances for one cycle, then RUN
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int TO_W       = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             McStartE,
  input  logic             McDone,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
  output logic [CNT_W-1:0] McCycles,
`endif
  output logic             McAbort
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  if ((MC_TIMEOUT < 2) || (MC_TIMEOUT > 255) || (MC_TIMEOUT > (2 ** TO_W)) || (CNT_W < 1)) begin : gBadParam
    $error("pipeline_hazard_ctrl: illegal MC_TIMEOUT/TO_W/CNT_W");
  end

  hazState_t       state, nextState;
  logic [TO_W-1:0] toCnt;
  logic            mcAbortQ;
  logic            lwStall, toExpire;
  logic            stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0]      fwdA, fwdB;

  forward_unit uFwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwdA),
    .ForwardBE (fwdB)
  );

  assign lwStall  = (ResultSrcE == RESULT_SRC_LOAD) && RegWriteE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign toExpire = (state == MC_WAIT) && !McDone && (toCnt == TO_LAST);

  always_comb begin
    nextState = state;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    case (state)
      RUN: begin
        // A single-cycle result (start and done together) needs no wait.
        if (McStartE && !McDone) begin
          nextState = MC_WAIT;
        end else if (PCSrcE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (lwStall) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      MC_WAIT: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
        if (McDone) begin
          nextState = MC_DRAIN;
        end else if (toExpire) begin
          nextState = RUN;
          flushE    = 1'b1;
        end
      end
      MC_DRAIN: nextState = RUN;
      default:  nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      toCnt    <= '0;
      mcAbortQ <= 1'b0;
    end else begin
      state <= nextState;
      if ((state == RUN) && (nextState == MC_WAIT)) toCnt <= '0;
      else if ((state == MC_WAIT) && (toCnt != TO_MAX)) toCnt <= toCnt + 1'b1;
      if (toExpire) mcAbortQ <= 1'b1;
    end
  end

  // Outputs are masked by rst so a mid-wait reset releases the pipeline at once.
  assign StallF    = stallF & ~rst;
  assign StallD    = stallD & ~rst;
  assign StallE    = stallE & ~rst;
  assign FlushD    = flushD & ~rst;
  assign FlushE    = flushE & ~rst;
  assign FlushM    = flushM & ~rst;
  assign ForwardAE = rst ? FWD_NONE : fwdA;
  assign ForwardBE = rst ? FWD_NONE : fwdB;
  assign McAbort   = mcAbortQ;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
      McCycles    <= '0;
    end else begin
      if (StallF)            StallCycles <= StallCycles + 1'b1;
      if (FlushD || FlushE)  FlushCount  <= FlushCount + 1'b1;
      if (state == MC_WAIT)  McCycles    <= McCycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MC_TIMEOUT=8).
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteE, RegWriteM, RegWriteW, PCSrcE, McStartE, McDone;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McAbort;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount, McCycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .McStartE(McStartE), .McDone(McDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZ_PERF_CNT_EN
    .StallCycles(StallCycles), .FlushCount(FlushCount), .McCycles(McCycles),
`endif
    .McAbort(McAbort)
  );

  // Control vector order: StallF StallD StallE FlushD FlushE FlushM
  wire [5:0] ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; McStartE = 0; McDone = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    RdE = 5'd5; ResultSrcE = 2'b01; RegWriteE = 1; Rs1D = 5'd5;
    RdM = 5'd3; RegWriteM = 1; Rs1E = 5'd3; Rs2E = 5'd3; PCSrcE = 1;
    step(); step();
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000); end
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=%b", {ForwardAE, ForwardBE}, 4'b0000); end
    checks++; if (McAbort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", McAbort); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL run_idle_ctl got=%b exp=%b", ctl, 6'b000000); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    RdE = 5'd5; ResultSrcE = 2'b01; RegWriteE = 1; Rs1D = 5'd5; Rs2D = 5'd1;
    #1;
    checks++; if (ctl !== 6'b110010) begin failures++; $display("FAIL loaduse_rs1 got=%b exp=%b", ctl, 6'b110010); end
    step();
    // Bubble now in E/M, load in W, add in E.
    clear_inputs();
    RdW = 5'd5; RegWriteW = 1; Rs1E = 5'd5; Rs2E = 5'd1;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL loaduse_one_bubble got=%b exp=%b", ctl, 6'b000000); end
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin failures++; $display("FAIL loaduse_fwd got=%b exp=%b", {ForwardAE, ForwardBE}, 4'b0100); end
    step();
    clear_inputs();
    RdE = 5'd7; ResultSrcE = 2'b01; RegWriteE = 1; Rs1D = 5'd2; Rs2D = 5'd7;
    #1;
    checks++; if (ctl !== 6'b110010) begin failures++; $display("FAIL loaduse_rs2 got=%b exp=%b", ctl, 6'b110010); end
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL loaduse_x0 got=%b exp=%b", ctl, 6'b000000); end
    RdE = 5'd7; Rs2D = 5'd7; ResultSrcE = 2'b00;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL loaduse_nonload got=%b exp=%b", ctl, 6'b000000); end
    step();
  endtask

  task automatic test_forward();
    logic [4:0] tRdM [5] = '{5'd3, 5'd3, 5'd0, 5'd0, 5'd3};
    logic       tWrM [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] tRdW [5] = '{5'd9, 5'd3, 5'd0, 5'd3, 5'd3};
    logic       tWrW [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] tRs2 [5] = '{5'd3, 5'd3, 5'd3, 5'd8, 5'd3};
    logic [3:0] tExp [5] = '{4'b1010, 4'b1010, 4'b0000, 4'b0100, 4'b0101};
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      Rs1E = 5'd3; Rs2E = tRs2[i];
      RdM = tRdM[i]; RegWriteM = tWrM[i]; RdW = tRdW[i]; RegWriteW = tWrW[i];
      #1;
      checks++;
      if ({ForwardAE, ForwardBE} !== tExp[i]) begin
        failures++; $display("FAIL fwd_vec%0d got=%b exp=%b", i, {ForwardAE, ForwardBE}, tExp[i]);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_control();
    clear_inputs();
    PCSrcE = 1;
    #1;
    checks++; if (ctl !== 6'b000110) begin failures++; $display("FAIL branch_flush got=%b exp=%b", ctl, 6'b000110); end
    RdE = 5'd5; ResultSrcE = 2'b01; RegWriteE = 1; Rs1D = 5'd5;
    #1;
    checks++; if (ctl !== 6'b000110) begin failures++; $display("FAIL branch_over_lw got=%b exp=%b", ctl, 6'b000110); end
    step();
    clear_inputs();
  endtask

  task automatic test_mc_done();
    clear_inputs();
    McStartE = 1;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL mc_issue_ctl got=%b exp=%b", ctl, 6'b000000); end
    step();
    McStartE = 0;
    for (int i = 1; i <= 5; i++) begin
      PCSrcE = (i == 2);
      McDone = (i == 5);
      #1;
      checks++; if (ctl !== 6'b111001) begin failures++; $display("FAIL mc_wait_c%0d got=%b exp=%b", i, ctl, 6'b111001); end
      step();
    end
    clear_inputs();
    McStartE = 1;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL mc_drain got=%b exp=%b", ctl, 6'b000000); end
    step();
    McStartE = 0;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL mc_back_run got=%b exp=%b", ctl, 6'b000000); end
    checks++; if (McAbort !== 1'b0) begin failures++; $display("FAIL mc_done_abort got=%b exp=0", McAbort); end
    step();
  endtask

  task automatic test_mc_single();
    clear_inputs();
    McStartE = 1; McDone = 1;
    step();
    clear_inputs();
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL mc_single got=%b exp=%b", ctl, 6'b000000); end
    step();
  endtask

  task automatic test_done_at_timeout();
    clear_inputs();
    McStartE = 1;
    step();
    McStartE = 0;
    for (int i = 1; i <= 8; i++) begin
      McDone = (i == 8);
      #1;
      checks++; if (ctl !== 6'b111001) begin failures++; $display("FAIL done_to_c%0d got=%b exp=%b", i, ctl, 6'b111001); end
      step();
    end
    McDone = 0;
    #1;
    checks++; if (McAbort !== 1'b0) begin failures++; $display("FAIL done_to_abort got=%b exp=0", McAbort); end
    step();
  endtask

  task automatic test_timeout();
    clear_inputs();
    McStartE = 1;
    step();
    McStartE = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++;
      if (ctl !== ((i == 8) ? 6'b111011 : 6'b111001)) begin
        failures++; $display("FAIL timeout_c%0d got=%b exp=%b", i, ctl, (i == 8) ? 6'b111011 : 6'b111001);
      end
      step();
    end
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL timeout_exit got=%b exp=%b", ctl, 6'b000000); end
    checks++; if (McAbort !== 1'b1) begin failures++; $display("FAIL timeout_abort got=%b exp=1", McAbort); end
    step(); step();
    checks++; if (McAbort !== 1'b1) begin failures++; $display("FAIL abort_sticky got=%b exp=1", McAbort); end
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    McStartE = 1;
    step();
    McStartE = 0;
    step(); step();
    checks++; if (ctl !== 6'b111001) begin failures++; $display("FAIL midrst_pre got=%b exp=%b", ctl, 6'b111001); end
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL midrst_drop got=%b exp=%b", ctl, 6'b000000); end
    checks++; if (McAbort !== 1'b0) begin failures++; $display("FAIL midrst_abort got=%b exp=0", McAbort); end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if ({StallCycles, FlushCount, McCycles} !== 96'd0) begin
      failures++; $display("FAIL midrst_perf got=%0d/%0d/%0d exp=0/0/0", StallCycles, FlushCount, McCycles);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL midrst_run got=%b exp=%b", ctl, 6'b000000); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_control();
    test_mc_done();
    test_mc_single();
    test_done_at_timeout();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates stage stall/flush enables, operand-forwarding selects for Execute, and multi-cycle execute-unit sequencing (iterative mul/div).
- Sits beside the datapath; drives the F/D, D/E and E/M pipeline-register enables and clears.

Parameters:
- MC_TIMEOUT, 64: max cycles in MC_WAIT before abort; range 2..255.
- TO_W, 8: timeout counter width; must hold MC_TIMEOUT.
- CNT_W, 32: perf counter width (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- Rs1D, Rs2D  in  5  decode-stage source regs (InstrD[19:15], [24:20]).
- Rs1E, Rs2E, RdE  in  5  execute-stage source/dest regs.
- ResultSrcE  in  2  execute-stage result select; 2'b01 = load.
- RegWriteE  in  1  execute-stage register write.
- RdM, RdW  in  5  mem/writeback dest regs.
- RegWriteM, RegWriteW  in  1  mem/writeback register write.
- PCSrcE  in  1  taken branch/jump resolved in E.
- McStartE  in  1  multi-cycle op in E (1-cycle pulse per issue).
- McDone  in  1  multi-cycle unit result valid (1-cycle pulse).
- StallF, StallD, StallE  out  1  hold PC, F/D, D/E registers.
- FlushD, FlushE, FlushM  out  1  synchronous clear of F/D, D/E, E/M registers.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 regfile, 01 W result, 10 M ALU result.
- McAbort  out  1  sticky: multi-cycle op timed out.

Behaviour:
- Reset: state=RUN, timeout counter=0, McAbort=0; while rst=1 all stall/flush outputs 0, forwarding 00.
- Forwarding (combinational, all states): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. ForwardBE same using Rs2E. M beats W.
- Load-use (RUN only): lwStall = ResultSrcE==01 && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). Asserts StallF, StallD, FlushE that cycle; exactly 1 bubble.
- Control hazard (RUN only): PCSrcE -> FlushD=1, FlushE=1 same cycle. If both PCSrcE and lwStall: flush wins, StallF=StallD=0.
- FSM states RUN, MC_WAIT, MC_DRAIN:
  - RUN -> MC_WAIT on McStartE (priority over PCSrcE/lwStall; those are re-evaluated once E advances). McStartE && McDone same cycle (single-cycle result): stay in RUN, no stall.
  - MC_WAIT: StallF=StallD=StallE=1, FlushM=1 (bubble into M); counter increments each cycle. PCSrcE, lwStall ignored.
  - MC_WAIT -> MC_DRAIN on McDone; MC_DRAIN lasts 1 cycle, no stalls, E advances with result; -> RUN.
  - MC_WAIT -> RUN on counter==MC_TIMEOUT-1 without McDone: set McAbort=1, assert FlushE for that cycle. McDone on the same cycle as timeout wins (normal completion, no abort).
  - McStartE in MC_WAIT/MC_DRAIN ignored.
- Counter cleared on entry to MC_WAIT; saturates, never wraps.
- Async rst mid MC_WAIT: immediate return to RUN, stalls drop in the same cycle.

Optional Feature:
- HAZ_PERF_CNT_EN: adds outputs StallCycles, FlushCount, McCycles (CNT_W each), reset 0, wrapping modulo 2^CNT_W. StallCycles +1 per cycle StallF=1; FlushCount +1 per cycle FlushD||FlushE; McCycles +1 per cycle in MC_WAIT.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package hazard_pkg: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; RESULT_SRC_LOAD=2'b01; FSM state enum (RUN, MC_WAIT, MC_DRAIN).
- Sub-module forward_unit: purely combinational ForwardAE/BE generation, instantiated once.

Test Plan:
- lw x5 then add x6,x5,x1 (RdE=5, ResultSrcE=01, Rs1D=5) -> StallF=StallD=FlushE=1 one cycle, then ForwardAE=01 on next E.
- add x3 then sub x4,x3,x3 (RdM=3, Rs1E=Rs2E=3) -> ForwardAE=ForwardBE=10; RdM=RdW=3 both writing -> 10; RdM=0 -> 00.
- PCSrcE=1 alongside lwStall -> FlushD=FlushE=1, StallF=StallD=0.
- McStartE pulse, McDone after 5 cycles -> StallF/D/E=1 for 5 cycles, FlushM=1, 1 MC_DRAIN cycle, back to RUN; McAbort=0.
- McStartE, no McDone, MC_TIMEOUT=8 -> exit after 8 cycles, FlushE=1 on exit, McAbort=1 held until rst.
- rst asserted 3 cycles into MC_WAIT -> stalls drop immediately, state RUN, counters (if HAZ_PERF_CNT_EN) = 0.
